// File: rtl/cascaded_pulse_generator.sv
// Multi-rate, run-gated tick source: a programmable base divider followed by a
// chain of mod-RATIO stages, each producing an aligned, registered one-cycle tick.
module cascaded_pulse_generator #(
    parameter int WIDTH  = 20,
    parameter int STAGES = 4,   // at least 2: stage 0 plus one or more mod-RATIO stages
    parameter int RATIO  = 10
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              run,
    input  logic              clear,
    input  logic              oneshot,
    input  logic [WIDTH-1:0]  period,
    output logic [STAGES-1:0] pulse,
    output logic              done
);

    localparam int SW = $clog2(RATIO);
    localparam logic [SW-1:0] LAST = SW'(RATIO - 1);

    logic [WIDTH-1:0]  period_q_r;
    logic [WIDTH-1:0]  period_q_s;
    logic [WIDTH-1:0]  count_r;
    logic [WIDTH-1:0]  count_s;
    logic [SW-1:0]     stage_r [1:STAGES-1];
    logic [SW-1:0]     stage_s [1:STAGES-1];
    logic [STAGES-1:0] pulse_r;
    logic [STAGES-1:0] pulse_s;
    logic [STAGES-1:0] wrap_s;
    logic              done_r;
    logic              done_s;
    logic              en_s;

    // Wrap chain: a stage wraps only when every faster stage wraps in the same cycle.
    always_comb begin
        en_s      = run & ~done_r;
        wrap_s    = '0;
        wrap_s[0] = en_s & (count_r == period_q_r);
        for (int k = 1; k < STAGES; k++) begin
            wrap_s[k] = wrap_s[k-1] & (stage_r[k] == LAST);
        end
    end

    // Next-state selection in priority order: reset/clear, halt, run, idle.
    always_comb begin
        period_q_s = period_q_r;
        count_s    = count_r;
        stage_s    = stage_r;
        pulse_s    = '0;
        done_s     = done_r;
        if (reset || clear) begin
            period_q_s = period;
            count_s    = '0;
            for (int k = 1; k < STAGES; k++) begin
                stage_s[k] = '0;
            end
            done_s = 1'b0;
        end else if (done_r) begin
            done_s = 1'b1;
        end else if (run) begin
            pulse_s = wrap_s;
            count_s = wrap_s[0] ? '0 : count_r + WIDTH'(1);
            for (int k = 1; k < STAGES; k++) begin
                if (wrap_s[k]) begin
                    stage_s[k] = '0;
                end else if (wrap_s[k-1]) begin
                    stage_s[k] = stage_r[k] + SW'(1);
                end else begin
                    stage_s[k] = stage_r[k];
                end
            end
            // A top-stage wrap already leaves every counter at zero; halting just latches done.
            if (oneshot && wrap_s[STAGES-1]) begin
                done_s = 1'b1;
            end else begin
                done_s = 1'b0;
            end
        end else begin
            pulse_s = '0;
        end
    end

    // State and output registers.
    always_ff @(posedge clock) begin
        period_q_r <= period_q_s;
        count_r    <= count_s;
        stage_r    <= stage_s;
        pulse_r    <= pulse_s;
        done_r     <= done_s;
    end

    assign pulse = pulse_r;
    assign done  = done_r;

endmodule

// File: tb/tb_cascaded_pulse_generator.sv
// Self-checking bench for cascaded_pulse_generator (STAGES=3, RATIO=10): an
// enabled-cycle reference model feeds a scoreboard, plus table and corner sequences.
module tb_cascaded_pulse_generator;

    localparam int WIDTH  = 20;
    localparam int STAGES = 3;
    localparam int RATIO  = 10;

    logic              clock;
    logic              reset;
    logic              run;
    logic              clear;
    logic              oneshot;
    logic [WIDTH-1:0]  period;
    logic [STAGES-1:0] pulse;
    logic              done;

    cascaded_pulse_generator #(.WIDTH(WIDTH), .STAGES(STAGES), .RATIO(RATIO)) dut (
        .clock   (clock),
        .reset   (reset),
        .run     (run),
        .clear   (clear),
        .oneshot (oneshot),
        .period  (period),
        .pulse   (pulse),
        .done    (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [STAGES-1:0] pulse;
        logic              done;
    } exp_t;

    typedef struct {
        int               run_mode;   // 0 idle, 1 continuous, 2 alternate
        logic             oneshot;
        logic [WIDTH-1:0] period;
        int               cycles;
        int               exp_t0;
        int               exp_t1;
        int               exp_t2;
        logic             exp_done;
    } vec_t;

    exp_t    sb_q[$];
    int      checks   = 0;
    int      failures = 0;

    // Reference model: counts enabled cycles since the last phase restart.
    longint  m_n    = 0;
    longint  m_pq   = 0;
    logic    m_done = 1'b0;

    int      ticks [STAGES];
    int      cyc;
    int      first_t0;
    int      last_t0;
    int      gap_t0;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic clear_stats();
        for (int k = 0; k < STAGES; k++) ticks[k] = 0;
        cyc      = 0;
        first_t0 = -1;
        last_t0  = -1;
        gap_t0   = -1;
    endtask

    function automatic exp_t model(input logic r, input logic c, input logic ru,
                                   input logic os, input logic [WIDTH-1:0] p);
        exp_t   e;
        longint div;
        e.pulse = '0;
        if (r || c) begin
            m_n    = 0;
            m_pq   = longint'(p);
            m_done = 1'b0;
        end else if (!m_done && ru) begin
            m_n = m_n + 1;
            div = m_pq + 1;
            for (int k = 0; k < STAGES; k++) begin
                e.pulse[k] = ((m_n % div) == 0);
                div = div * RATIO;
            end
            if (e.pulse[STAGES-1]) m_n = 0;
            if (os && e.pulse[STAGES-1]) m_done = 1'b1;
        end
        e.done = m_done;
        return e;
    endfunction

    task automatic step(input logic r, input logic c, input logic ru,
                        input logic os, input logic [WIDTH-1:0] p);
        exp_t e;
        @(negedge clock);
        reset   = r;
        clear   = c;
        run     = ru;
        oneshot = os;
        period  = p;
        sb_q.push_back(model(r, c, ru, os, p));
        @(posedge clock);
        #1;
        e = sb_q.pop_front();
        chk("pulse", longint'(pulse), longint'(e.pulse));
        chk("done", longint'(done), longint'(e.done));
        cyc++;
        for (int k = 0; k < STAGES; k++) begin
            if (pulse[k] === 1'b1) ticks[k]++;
        end
        if (pulse[0] === 1'b1) begin
            if (first_t0 < 0) first_t0 = cyc;
            if (last_t0 >= 0) gap_t0 = cyc - last_t0;
            last_t0 = cyc;
        end
    endtask

    vec_t vecs [5];

    initial begin
        reset = 1'b1; clear = 1'b0; run = 1'b0; oneshot = 1'b0; period = '0;

        vecs[0] = '{1, 1'b0, 20'd4, 500,  100, 10, 1, 1'b0};
        vecs[1] = '{2, 1'b0, 20'd4, 1000, 100, 10, 1, 1'b0};
        vecs[2] = '{1, 1'b1, 20'd1, 300,  100, 10, 1, 1'b1};
        vecs[3] = '{1, 1'b0, 20'd0, 100,  100, 10, 1, 1'b0};
        vecs[4] = '{0, 1'b0, 20'd3, 50,   0,   0,  0, 1'b0};

        // Table-driven runs: reset with the vector's period, then drive the run pattern.
        for (int i = 0; i < 5; i++) begin
            logic ru;
            step(1'b1, 1'b0, 1'b0, vecs[i].oneshot, vecs[i].period);
            clear_stats();
            for (int c = 1; c <= vecs[i].cycles; c++) begin
                ru = (vecs[i].run_mode == 1) || (vecs[i].run_mode == 2 && (c % 2) == 1);
                step(1'b0, 1'b0, ru, vecs[i].oneshot, vecs[i].period);
            end
            chk($sformatf("vec%0d_ticks0", i), ticks[0], vecs[i].exp_t0);
            chk($sformatf("vec%0d_ticks1", i), ticks[1], vecs[i].exp_t1);
            chk($sformatf("vec%0d_ticks2", i), ticks[2], vecs[i].exp_t2);
            chk($sformatf("vec%0d_done", i), longint'(done), longint'(vecs[i].exp_done));
        end

        // Period change mid-run takes effect only at the next clear.
        step(1'b1, 1'b0, 1'b0, 1'b0, 20'd4);
        clear_stats();
        for (int c = 0; c < 12; c++) step(1'b0, 1'b0, 1'b1, 1'b0, 20'd4);
        for (int c = 0; c < 20; c++) step(1'b0, 1'b0, 1'b1, 1'b0, 20'd9);
        chk("chg_gap_before_clear", gap_t0, 5);
        chk("chg_ticks_before_clear", ticks[0], 6);
        step(1'b0, 1'b1, 1'b1, 1'b0, 20'd9);
        clear_stats();
        for (int c = 0; c < 20; c++) step(1'b0, 1'b0, 1'b1, 1'b0, 20'd9);
        chk("chg_first_after_clear", first_t0, 10);
        chk("chg_gap_after_clear", gap_t0, 10);

        // Clear in the cycle where count == period_q suppresses that tick.
        step(1'b1, 1'b0, 1'b0, 1'b0, 20'd4);
        for (int c = 0; c < 4; c++) step(1'b0, 1'b0, 1'b1, 1'b0, 20'd4);
        step(1'b0, 1'b1, 1'b1, 1'b0, 20'd4);
        chk("clr_wrap_no_tick", longint'(pulse), 0);
        clear_stats();
        for (int c = 0; c < 7; c++) step(1'b0, 1'b0, 1'b1, 1'b0, 20'd4);
        chk("clr_wrap_first", first_t0, 5);

        // One-shot halt, no resume on oneshot=0, restart by clear.
        step(1'b1, 1'b0, 1'b0, 1'b1, 20'd1);
        clear_stats();
        for (int c = 0; c < 200; c++) step(1'b0, 1'b0, 1'b1, 1'b1, 20'd1);
        chk("os_top_cycle", last_t0, 200);
        chk("os_done", longint'(done), 1);
        clear_stats();
        for (int c = 0; c < 10; c++) step(1'b0, 1'b0, 1'b1, 1'b0, 20'd1);
        chk("os_no_resume", ticks[0], 0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 20'd1);
        chk("os_clear_done", longint'(done), 0);
        clear_stats();
        for (int c = 0; c < 4; c++) step(1'b0, 1'b0, 1'b1, 1'b0, 20'd1);
        chk("os_first_after_clear", first_t0, 2);

        // Reset while halted drops done and restarts from phase 0.
        for (int c = 0; c < 200; c++) step(1'b0, 1'b0, 1'b1, 1'b1, 20'd1);
        step(1'b1, 1'b0, 1'b1, 1'b0, 20'd2);
        chk("rst_done_low", longint'(done), 0);
        clear_stats();
        for (int c = 0; c < 6; c++) step(1'b0, 1'b0, 1'b1, 1'b0, 20'd2);
        chk("rst_first_tick", first_t0, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
